// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, the line/frame total helper and the sync bundle type.
// Constants only; no clocked logic lives here.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Raw (polarity-free) asserted levels; polarity is applied after the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bundle_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel-generator side drives en/sync_clr, timing generator drives the rest.
// Plain wires; no handshake, en stalls the whole raster.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic             sync_clr;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic             de;

  modport master (
    input  en, sync_clr,
    output x, y, active, line_start, frame_start, hsync, vsync, de
  );

  modport slave (
    output en, sync_clr,
    input  x, y, active, line_start, frame_start, hsync, vsync, de
  );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// DEPTH-stage enable-gated shift register with async reset and sync clear to RST_VAL.
// Latency DEPTH enabled cycles; DEPTH=0 is a pure passthrough.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type T       = sync_bundle_t,
  parameter T    RST_VAL = '0
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{pixel_clk, reset, en, clr};
      assign q = d;
    end else begin : g_pipe
      T stage [DEPTH];

      always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with undelayed x/y/markers and sync/de delayed PIPE_DLY enabled cycles.
// en stalls counters and delay line together; sync_clr restarts the raster at (0,0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10,
  parameter int PIPE_DLY = 2
) (
  input  logic              pixel_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Inclusive bounds keep every constant below 2^CNT_W even when TOTAL == 2^CNT_W.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam sync_bundle_t     SYNC_IDLE = '0;

  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             active_w;
  sync_bundle_t     raw;
  sync_bundle_t     dly;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vga.sync_clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vga.en) begin
      if (x_q == H_LAST) begin
        x_q <= '0;
        y_q <= (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign active_w = (x_q < H_ACT) && (y_q < V_ACT);
  assign raw.hs   = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign raw.vs   = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
  assign raw.de   = active_w;

  vga_delay_line #(
    .DEPTH   (PIPE_DLY),
    .T       (sync_bundle_t),
    .RST_VAL (SYNC_IDLE)
  ) u_delay_line (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .en        (vga.en),
    .clr       (vga.sync_clr),
    .d         (raw),
    .q         (dly)
  );

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.active      = active_w;
  assign vga.line_start  = (x_q == '0);
  assign vga.frame_start = (x_q == '0) && (y_q == '0);
  assign vga.hsync       = (HS_POL != 0) ? dly.hs : ~dly.hs;
  assign vga.vsync       = (VS_POL != 0) ? dly.vs : ~dly.vs;
  assign vga.de          = dly.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480, a tiny raster for vertical/frame behaviour, and 800x600.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        act;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int hpol, vpol, dly;
  } tcfg_t;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;
  logic en        = 1'b0;
  logic sync_clr  = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if #(.CNT_W(10)) if_a ();
  vga_timing_gen_if #(.CNT_W(4))  if_b ();
  vga_timing_gen_if #(.CNT_W(11)) if_c ();

  assign if_a.en = en;  assign if_a.sync_clr = sync_clr;
  assign if_b.en = en;  assign if_b.sync_clr = sync_clr;
  assign if_c.en = en;  assign if_c.sync_clr = sync_clr;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
    .HS_POL(0), .VS_POL(0), .CNT_W(10), .PIPE_DLY(2)
  ) u_dut_a (.pixel_clk(pixel_clk), .reset(reset), .vga(if_a));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CNT_W(4), .PIPE_DLY(2)
  ) u_dut_b (.pixel_clk(pixel_clk), .reset(reset), .vga(if_b));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1),  .V_SYNC(4),   .V_BP(23),
    .HS_POL(1), .VS_POL(1), .CNT_W(11), .PIPE_DLY(0)
  ) u_dut_c (.pixel_clk(pixel_clk), .reset(reset), .vga(if_c));

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {16'(if_a.x), 16'(if_a.y), if_a.active, if_a.line_start, if_a.frame_start,
                  if_a.hsync, if_a.vsync, if_a.de};
  assign obs_b = {16'(if_b.x), 16'(if_b.y), if_b.active, if_b.line_start, if_b.frame_start,
                  if_b.hsync, if_b.vsync, if_b.de};
  assign obs_c = {16'(if_c.x), 16'(if_c.y), if_c.active, if_c.line_start, if_c.frame_start,
                  if_c.hsync, if_c.vsync, if_c.de};

  tcfg_t cfg_a, cfg_b, cfg_c;
  int n_checks = 0;
  int n_errors = 0;
  int steps    = 0;
  int bad_a    = 0;
  int bad_b    = 0;
  int bad_c    = 0;

  int a_first_hs, a_hs_cnt, a_de_cnt, a_ls_cnt, b_fs_cnt, b_vs_cnt, c_first_hs, c_hs_cnt;
  int last_ls, period, hs_w, guard;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs after s enabled cycles since reset/clear.
  function automatic obs_t expect_at(input tcfg_t c, input int s);
    obs_t o;
    int ht, vt, x, y, sd, xd, yd;
    logic hr, vr, ar;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    x  = s % ht;
    y  = (s / ht) % vt;
    o.x   = 16'(x);
    o.y   = 16'(y);
    o.act = (x < c.ha) && (y < c.va);
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
    hr = 1'b0; vr = 1'b0; ar = 1'b0;
    sd = s - c.dly;
    if (sd >= 0) begin
      xd = sd % ht;
      yd = (sd / ht) % vt;
      hr = (xd >= c.ha + c.hfp) && (xd < c.ha + c.hfp + c.hsw);
      vr = (yd >= c.va + c.vfp) && (yd < c.va + c.vfp + c.vsw);
      ar = (xd < c.ha) && (yd < c.va);
    end
    o.hs = (c.hpol != 0) ? hr : !hr;
    o.vs = (c.vpol != 0) ? vr : !vr;
    o.de = ar;
    return o;
  endfunction

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic compare_all();
    if (obs_a !== expect_at(cfg_a, steps)) bad_a++;
    if (obs_b !== expect_at(cfg_b, steps)) bad_b++;
    if (obs_c !== expect_at(cfg_c, steps)) bad_c++;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      compare_all();
      tick();
      if (en) steps++;
    end
  endtask

  task automatic flush_model(input string tag);
    check_val({tag, "_a_mism"}, bad_a, 0);
    check_val({tag, "_b_mism"}, bad_b, 0);
    check_val({tag, "_c_mism"}, bad_c, 0);
    bad_a = 0; bad_b = 0; bad_c = 0;
  endtask

  initial begin
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
    cfg_b = '{8, 2, 3, 3, 4, 1, 2, 1, 0, 0, 2};
    cfg_c = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 0};

    // Reset state
    tick(); tick();
    check_val("rst_a_x", 32'(if_a.x), 0);
    check_val("rst_a_y", 32'(if_a.y), 0);
    check_val("rst_a_hsync", 32'(if_a.hsync), 1);
    check_val("rst_a_vsync", 32'(if_a.vsync), 1);
    check_val("rst_a_de", 32'(if_a.de), 0);
    check_val("rst_a_line_start", 32'(if_a.line_start), 1);
    check_val("rst_a_frame_start", 32'(if_a.frame_start), 1);
    check_val("rst_c_hsync", 32'(if_c.hsync), 0);
    check_val("rst_c_vsync", 32'(if_c.vsync), 0);
    check_val("rst_b_de", 32'(if_b.de), 0);
    reset = 1'b0;
    steps = 0;

    // One full default line plus enough for the 800x600 hsync window
    a_first_hs = -1; a_hs_cnt = 0; a_de_cnt = 0; a_ls_cnt = 0;
    b_fs_cnt = 0; b_vs_cnt = 0; c_first_hs = -1; c_hs_cnt = 0;
    for (int s = 0; s < 1056; s++) begin
      en = 1'b1;
      compare_all();
      if (s < 800) begin
        if (!if_a.hsync) begin
          if (a_first_hs < 0) a_first_hs = s;
          a_hs_cnt++;
        end
        if (if_a.de) a_de_cnt++;
        if (if_a.line_start) a_ls_cnt++;
        if (if_b.frame_start) b_fs_cnt++;
        if (!if_b.vsync) b_vs_cnt++;
      end
      if (if_c.hsync) begin
        if (c_first_hs < 0) c_first_hs = s;
        c_hs_cnt++;
      end
      if (s == 799) begin
        check_val("a_x_last", 32'(if_a.x), 799);
        check_val("a_y_before_wrap", 32'(if_a.y), 0);
      end
      if (s == 800) begin
        check_val("a_x_wrap", 32'(if_a.x), 0);
        check_val("a_y_after_wrap", 32'(if_a.y), 1);
        check_val("a_line_start_wrap", 32'(if_a.line_start), 1);
      end
      tick();
      steps++;
    end
    flush_model("p1");
    check_val("a_hsync_first_low", a_first_hs, 658);
    check_val("a_hsync_width", a_hs_cnt, 96);
    check_val("a_de_count_line0", a_de_cnt, 640);
    check_val("a_line_start_count", a_ls_cnt, 1);
    check_val("b_frame_start_count", b_fs_cnt, 7);
    check_val("b_vsync_low_count", b_vs_cnt, 192);
    check_val("c_hsync_first_high", c_first_hs, 840);
    check_val("c_hsync_width", c_hs_cnt, 128);

    // Random clock-enable gating
    last_ls = -1; period = 0; hs_w = 0;
    for (int i = 0; i < 4000; i++) begin
      en = 1'($urandom_range(0, 1));
      compare_all();
      if (en) begin
        if (if_a.line_start) begin
          if (last_ls >= 0) period = steps - last_ls;
          last_ls = steps;
        end
        if (steps >= 1600 && steps < 2400 && !if_a.hsync) hs_w++;
      end
      tick();
      if (en) steps++;
    end
    flush_model("p2");
    check_val("a_line_period_en", period, 800);
    check_val("a_hsync_width_en", hs_w, 96);

    // Genlock restart while the small raster sits inside both sync pulses
    guard = 0;
    while ((steps % 128) != 92 && guard < 200) begin
      run(1, 1'b0);
      guard++;
    end
    check_val("b_x_pre_clr", 32'(if_b.x), 12);
    check_val("b_y_pre_clr", 32'(if_b.y), 5);
    check_val("b_hsync_pre_clr", 32'(if_b.hsync), 0);
    check_val("b_vsync_pre_clr", 32'(if_b.vsync), 0);
    en = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    steps = 0;
    check_val("b_x_clr", 32'(if_b.x), 0);
    check_val("b_y_clr", 32'(if_b.y), 0);
    check_val("b_frame_start_clr", 32'(if_b.frame_start), 1);
    check_val("b_hsync_clr", 32'(if_b.hsync), 1);
    check_val("b_vsync_clr", 32'(if_b.vsync), 1);
    check_val("a_x_clr", 32'(if_a.x), 0);
    check_val("a_frame_start_clr", 32'(if_a.frame_start), 1);
    check_val("a_de_clr0", 32'(if_a.de), 0);
    run(1, 1'b0);
    check_val("a_de_clr1", 32'(if_a.de), 0);
    run(1, 1'b0);
    check_val("a_de_clr2", 32'(if_a.de), 1);
    check_val("b_de_clr2", 32'(if_b.de), 1);
    run(300, 1'b1);
    flush_model("p3");

    // Asynchronous reset mid-line
    run(500 - steps, 1'b0);
    check_val("a_x_pre_rst", 32'(if_a.x), 500);
    check_val("a_de_pre_rst", 32'(if_a.de), 1);
    #3;
    reset = 1'b1;
    #1;
    check_val("a_x_async_rst", 32'(if_a.x), 0);
    check_val("a_y_async_rst", 32'(if_a.y), 0);
    check_val("a_hsync_async_rst", 32'(if_a.hsync), 1);
    check_val("a_vsync_async_rst", 32'(if_a.vsync), 1);
    check_val("a_de_async_rst", 32'(if_a.de), 0);
    check_val("c_hsync_async_rst", 32'(if_c.hsync), 0);
    tick();
    reset = 1'b0;
    steps = 0;
    run(1200, 1'b1);
    flush_model("p4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
